// File: rtl/gcbp_field_gen.sv
`default_nettype none
// ============================================================================
// Module   : gcbp_field_gen
// Function : Two-field interlaced raster generator. Produces the field flag,
//            blanking flags, pixel/line position and a frame-start strobe
//            that marks pixel (0,0) of every field 0.
// Revision : 1.0 - initial release
// ============================================================================
module gcbp_field_gen #(
  parameter int C_CNT_BITS = 11,
  parameter int C_H_ACTIVE = 720,
  parameter int C_H_TOTAL  = 858,
  parameter int C_V_ACTIVE = 240,
  parameter int C_F0_LINES = 263,
  parameter int C_F1_LINES = 262
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_enable,
  output logic                  o_field_0,
  output logic                  o_hblank,
  output logic                  o_vblank,
  output logic                  o_active,
  output logic [C_CNT_BITS-1:0] o_pixel_x,
  output logic [C_CNT_BITS-1:0] o_line_y,
  output logic                  o_frame_start,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FIELD_0 = 2'd1;
  localparam logic [1:0] S_FIELD_1 = 2'd2;

  localparam logic [C_CNT_BITS-1:0] C_ONE      = C_CNT_BITS'(1);
  localparam logic [C_CNT_BITS-1:0] C_X_LAST   = C_CNT_BITS'(C_H_TOTAL - 1);
  localparam logic [C_CNT_BITS-1:0] C_Y0_LAST  = C_CNT_BITS'(C_F0_LINES - 1);
  localparam logic [C_CNT_BITS-1:0] C_Y1_LAST  = C_CNT_BITS'(C_F1_LINES - 1);
  localparam logic [C_CNT_BITS-1:0] C_X_ACTIVE = C_CNT_BITS'(C_H_ACTIVE);
  localparam logic [C_CNT_BITS-1:0] C_Y_ACTIVE = C_CNT_BITS'(C_V_ACTIVE);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [C_CNT_BITS-1:0] pix_x;
  logic [C_CNT_BITS-1:0] pix_x_nxt;
  logic [C_CNT_BITS-1:0] line_y;
  logic [C_CNT_BITS-1:0] line_y_nxt;
  logic                  frame_start;
  logic                  frame_start_nxt;
  logic                  line_end;
  logic                  busy;

  assign line_end = (pix_x == C_X_LAST);

  // State, counter and frame-start registers; reset forces idle immediately.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state       <= S_IDLE;
      pix_x       <= '0;
      line_y      <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_x       <= pix_x_nxt;
      line_y      <= line_y_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Next-state and counter advance; enable is only looked at in idle and at
  // the very last pixel of field 1 so a frame is never cut short.
  always_comb begin
    state_nxt       = state;
    pix_x_nxt       = pix_x;
    line_y_nxt      = line_y;
    frame_start_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        pix_x_nxt  = '0;
        line_y_nxt = '0;
        if (i_enable) begin
          state_nxt       = S_FIELD_0;
          frame_start_nxt = 1'b1;
        end
      end
      S_FIELD_0: begin
        if (line_end) begin
          pix_x_nxt = '0;
          if (line_y == C_Y0_LAST) begin
            state_nxt  = S_FIELD_1;
            line_y_nxt = '0;
          end else begin
            line_y_nxt = line_y + C_ONE;
          end
        end else begin
          pix_x_nxt = pix_x + C_ONE;
        end
      end
      S_FIELD_1: begin
        if (line_end) begin
          pix_x_nxt = '0;
          if (line_y == C_Y1_LAST) begin
            line_y_nxt = '0;
            if (i_enable) begin
              state_nxt       = S_FIELD_0;
              frame_start_nxt = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            line_y_nxt = line_y + C_ONE;
          end
        end else begin
          pix_x_nxt = pix_x + C_ONE;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        pix_x_nxt  = '0;
        line_y_nxt = '0;
      end
    endcase
  end

  // Outputs decoded from registers only; blanking is forced high while idle.
  always_comb begin
    busy          = (state != S_IDLE);
    o_busy        = busy;
    o_field_0     = (state != S_FIELD_1);
    o_hblank      = !busy || (pix_x >= C_X_ACTIVE);
    o_vblank      = !busy || (line_y >= C_Y_ACTIVE);
    o_active      = busy && (pix_x < C_X_ACTIVE) && (line_y < C_Y_ACTIVE);
    o_pixel_x     = pix_x;
    o_line_y      = line_y;
    o_frame_start = frame_start;
  end

endmodule
`default_nettype wire

// File: tb/tb_gcbp_field_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcbp_field_gen
// Function : Directed self-checking bench for gcbp_field_gen using a small
//            6x(4+3) raster (42-cycle frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcbp_field_gen;

  localparam int CB = 11;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          field_0, hblank, vblank, active, frame_start, busy;
  logic [CB-1:0] pixel_x, line_y;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fs_cnt, f0_hi, f0_lo, act_cnt;
  int max_x, max_y0, max_y1;
  logic prev_f0;

  gcbp_field_gen #(
    .C_CNT_BITS(CB), .C_H_ACTIVE(4), .C_H_TOTAL(6),
    .C_V_ACTIVE(2), .C_F0_LINES(4), .C_F1_LINES(3)
  ) dut (
    .i_clk(clk), .i_resetn(resetn), .i_enable(enable),
    .o_field_0(field_0), .o_hblank(hblank), .o_vblank(vblank),
    .o_active(active), .o_pixel_x(pixel_x), .o_line_y(line_y),
    .o_frame_start(frame_start), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".field_0"}, field_0, 1);
    chk({tag, ".hblank"}, hblank, 1);
    chk({tag, ".vblank"}, vblank, 1);
    chk({tag, ".active"}, active, 0);
    chk({tag, ".x"}, pixel_x, 0);
    chk({tag, ".y"}, line_y, 0);
    chk({tag, ".fs"}, frame_start, 0);
  endtask

  // Expected raster position for cycle k of a frame (k=0 is the frame-start cycle)
  task automatic chk_pos(input string tag, input int k);
    int p, ex, ey, ef0;
    p   = k % 42;
    ef0 = (p < 24) ? 1 : 0;
    ey  = (p < 24) ? p / 6 : (p - 24) / 6;
    ex  = (p < 24) ? p % 6 : (p - 24) % 6;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".field_0"}, field_0, ef0);
    chk({tag, ".x"}, pixel_x, ex);
    chk({tag, ".y"}, line_y, ey);
    chk({tag, ".fs"}, frame_start, (p == 0) ? 1 : 0);
    chk({tag, ".hblank"}, hblank, (ex >= 4) ? 1 : 0);
    chk({tag, ".vblank"}, vblank, (ey >= 2) ? 1 : 0);
    chk({tag, ".active"}, active, (ex < 4 && ey < 2) ? 1 : 0);
  endtask

  task automatic clr_stats();
    fs_cnt = 0; f0_hi = 0; f0_lo = 0; act_cnt = 0;
    max_x = 0; max_y0 = 0; max_y1 = 0;
  endtask

  task automatic acc_stats();
    if (frame_start) fs_cnt++;
    if (field_0) f0_hi++; else f0_lo++;
    if (active) act_cnt++;
    if (int'(pixel_x) > max_x) max_x = int'(pixel_x);
    if (field_0 && int'(line_y) > max_y0) max_y0 = int'(line_y);
    if (!field_0 && int'(line_y) > max_y1) max_y1 = int'(line_y);
  endtask

  initial begin
    // ---------------- Reset with enable high ----------------
    resetn = 1'b0;
    enable = 1'b1;
    tick(); tick(); tick();
    chk_idle("reset");

    // ---------------- Continuous: first pulse one edge after release ----------------
    resetn = 1'b1;
    tick();
    clr_stats();
    prev_f0 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) tick();
      chk_pos("cont", k);
      if (frame_start && k > 0) chk("cont.fs_on_rise", {prev_f0, field_0}, 2'b01);
      acc_stats();
      prev_f0 = field_0;
    end
    chk("cont.fs_count", fs_cnt, 5);
    chk("cont.max_x", max_x, 5);
    chk("cont.max_y_f0", max_y0, 3);
    chk("cont.max_y_f1", max_y1, 2);

    // Drop enable in field 1 (k=199 is frame cycle 31): frame completes at k=209
    enable = 1'b0;
    for (int k = 200; k < 210; k++) begin
      tick();
      chk_pos("cont_tail", k);
    end
    tick();
    chk_idle("cont_end");

    // ---------------- Single frame from a one-cycle enable pulse ----------------
    enable = 1'b1;
    tick();
    enable = 1'b0;
    clr_stats();
    for (int k = 0; k < 42; k++) begin
      if (k > 0) tick();
      chk_pos("single", k);
      acc_stats();
    end
    chk("single.fs_count", fs_cnt, 1);
    chk("single.f0_high", f0_hi, 24);
    chk("single.f0_low", f0_lo, 18);
    chk("single.active", act_cnt, 16);
    tick();
    chk_idle("single_end");
    tick(); tick();
    chk_idle("single_idle");

    // ---------------- Enable dropped at cycle 10 of field 0 ----------------
    enable = 1'b1;
    tick();
    clr_stats();
    for (int k = 0; k < 42; k++) begin
      if (k > 0) tick();
      if (k == 10) enable = 1'b0;
      chk_pos("drop", k);
      acc_stats();
    end
    chk("drop.fs_count", fs_cnt, 1);
    clr_stats();
    for (int k = 0; k < 5; k++) begin
      tick();
      acc_stats();
      chk_idle("drop_idle");
    end
    chk("drop.no_more_fs", fs_cnt, 0);

    // ---------------- Enable only on the last cycle of field 1 ----------------
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 42; k++) begin
      if (k > 0) tick();
      chk_pos("edge", k);
      if (k == 41) enable = 1'b1;
    end
    tick();
    enable = 1'b0;
    chk("edge.fs", frame_start, 1);
    chk("edge.busy", busy, 1);
    chk("edge.field_0", field_0, 1);
    chk_pos("edge_next", 0);

    // ---------------- Reset for one edge at y=1 of field 1 ----------------
    for (int k = 1; k <= 30; k++) tick();
    chk_pos("pre_rst", 30);
    chk("pre_rst.y1", line_y, 1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_idle("mid_rst");
    clr_stats();
    for (int k = 0; k < 5; k++) begin
      tick();
      acc_stats();
      chk_idle("post_rst");
    end
    chk("post_rst.no_fs", fs_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
